// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - configuration word stream and readback word bundle
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready,
    input  rb_data,
    input  rb_valid
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready,
    output rb_data,
    output rb_valid
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serialises config words onto a ccff chain and captures readback
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic               prog_clk,
  input  logic               pReset,
  input  logic               start,
  ccff_chain_loader_if.slave bus,
  output logic               ccff_head,
  output logic               config_enable,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  bits_left;
  logic [CNT_W-1:0]  word_left;
  logic [CNT_W-1:0]  n_next;
  logic [WORD_W-1:0] word_sr;
  logic [WORD_W-1:0] rb_sr;
  logic [WORD_W-1:0] rb_mask;
  logic [WORD_W-1:0] rb_next;

  assign bus.cfg_ready = (state == FETCH);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  // Length of the next word: a full word, or only what is left of the chain
  always_comb begin
    n_next = CNT_W'(WORD_W);
    if (int'(bits_left) < WORD_W) begin
      n_next = bits_left;
    end
  end

  // Readback with the current pre-shift tail bit merged in at the one-hot position
  always_comb begin
    rb_next = rb_sr;
    if (ccff_tail) begin
      rb_next = rb_sr | rb_mask;
    end
  end

  // Load sequencing, serialiser and readback capture
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state         <= IDLE;
      bits_left     <= '0;
      word_left     <= '0;
      word_sr       <= '0;
      rb_sr         <= '0;
      rb_mask       <= '0;
      ccff_head     <= 1'b0;
      config_enable <= 1'b0;
      bus.rb_data   <= '0;
      bus.rb_valid  <= 1'b0;
    end else begin
      bus.rb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bits_left <= CNT_W'(CHAIN_LEN);
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (bus.cfg_valid) begin
            word_sr       <= bus.cfg_data >> 1;
            ccff_head     <= bus.cfg_data[0];
            config_enable <= 1'b1;
            word_left     <= n_next;
            rb_sr         <= '0;
            rb_mask       <= WORD_W'(1);
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          // The chain takes ccff_head on this edge; the next word bit is lined up behind it
          ccff_head <= word_sr[0];
          word_sr   <= word_sr >> 1;
          rb_sr     <= rb_next;
          rb_mask   <= rb_mask << 1;
          word_left <= word_left - CNT_W'(1);
          if (bits_left != '0) begin
            bits_left <= bits_left - CNT_W'(1);
          end
          if (word_left == CNT_W'(1)) begin
            // Unshifted upper bits of a short final word are dropped here
            ccff_head     <= 1'b0;
            config_enable <= 1'b0;
            bus.rb_valid  <= 1'b1;
            bus.rb_data   <= rb_next;
            state         <= (bits_left == CNT_W'(1)) ? DONE : FETCH;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - randomized bench for ccff_chain_loader against a bitstream model
module tb_ccff_chain_loader;
  localparam int NA = 48;
  localparam int NB = 10;
  localparam int W  = 8;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic preset_a, preset_b, start_a, start_b;
  logic head_a, head_b, en_a, en_b, busy_a, busy_b, done_a, done_b;
  logic [NA-1:0] chain_a, init_val_a;
  logic [NB-1:0] chain_b, init_val_b;
  logic init_a, init_b;

  ccff_chain_loader_if #(.WORD_W(W)) ifa ();
  ccff_chain_loader_if #(.WORD_W(W)) ifb ();

  ccff_chain_loader #(.CHAIN_LEN(NA), .WORD_W(W)) u_a (
    .prog_clk(prog_clk), .pReset(preset_a), .start(start_a), .bus(ifa),
    .ccff_head(head_a), .config_enable(en_a), .ccff_tail(chain_a[0]),
    .busy(busy_a), .done(done_a)
  );

  ccff_chain_loader #(.CHAIN_LEN(NB), .WORD_W(W)) u_b (
    .prog_clk(prog_clk), .pReset(preset_b), .start(start_b), .bus(ifb),
    .ccff_head(head_b), .config_enable(en_b), .ccff_tail(chain_b[0]),
    .busy(busy_b), .done(done_b)
  );

  // Tile chains: bit 0 is the flop nearest ccff_tail
  always @(posedge prog_clk) begin
    if (init_a) chain_a <= init_val_a;
    else if (en_a) chain_a <= {head_a, chain_a[NA-1:1]};
    if (init_b) chain_b <= init_val_b;
    else if (en_b) chain_b <= {head_b, chain_b[NB-1:1]};
  end

  int sh_a = 0, dn_a = 0, run_a = 0, gap_a = 0;
  int sh_b = 0, dn_b = 0, run_b = 0;
  bit seen_a = 1'b0;
  logic [7:0] rbq_a[$], rbq_b[$];
  int runs_a[$], gaps_a[$], runs_b[$];

  // Observers: shift counts, done pulses, readback words, enable run and gap lengths
  always @(posedge prog_clk) begin
    if (en_a) sh_a <= sh_a + 1;
    if (done_a) dn_a <= dn_a + 1;
    if (ifa.rb_valid) rbq_a.push_back(ifa.rb_data);
    if (en_a) run_a <= run_a + 1;
    else if (run_a != 0) begin runs_a.push_back(run_a); run_a <= 0; end
    if (!busy_a) begin gap_a <= 0; seen_a <= 1'b0; end
    else if (en_a) begin
      if (seen_a && gap_a != 0) gaps_a.push_back(gap_a);
      gap_a <= 0; seen_a <= 1'b1;
    end else if (seen_a) gap_a <= gap_a + 1;
    if (en_b) sh_b <= sh_b + 1;
    if (done_b) dn_b <= dn_b + 1;
    if (ifb.rb_valid) rbq_b.push_back(ifb.rb_data);
    if (en_b) run_b <= run_b + 1;
    else if (run_b != 0) begin runs_b.push_back(run_b); run_b <= 0; end
  end

  int n_pass = 0, n_total = 0;
  bit mq_a[$], mq_b[$];

  // Reference: the chain as a FIFO of bits, front = flop nearest the tail
  function automatic logic [7:0] model_word(input int sel, input logic [7:0] d, input int n);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) begin r[i] = mq_a.pop_front(); mq_a.push_back(d[i]); end
      else begin r[i] = mq_b.pop_front(); mq_b.push_back(d[i]); end
    end
    return r;
  endfunction

  function automatic void model_load(input int sel, input logic [7:0] w [8], input int nw, output logic [7:0] r [8]);
    int left;
    int n;
    left = (sel == 0) ? NA : NB;
    for (int k = 0; k < 8; k++) r[k] = 8'h00;
    for (int k = 0; k < nw; k++) begin
      n = (left < W) ? left : W;
      r[k] = model_word(sel, w[k], n);
      left -= n;
    end
  endfunction

  function automatic int chain_err(input int sel);
    int e;
    e = 0;
    if (sel == 0) begin
      if (mq_a.size() != NA) return -1;
      for (int i = 0; i < NA; i++) if (chain_a[i] !== mq_a[i]) e++;
    end else begin
      if (mq_b.size() != NB) return -1;
      for (int i = 0; i < NB; i++) if (chain_b[i] !== mq_b[i]) e++;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic set_cfg(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin ifa.cfg_valid = v; ifa.cfg_data = d; end
    else begin ifb.cfg_valid = v; ifb.cfg_data = d; end
  endtask

  task automatic send_word(input int sel, input logic [7:0] d, output bit to);
    int b;
    b = 0;
    to = 1'b0;
    set_cfg(sel, 1'b1, d);
    while (((sel == 0) ? ifa.cfg_ready : ifb.cfg_ready) !== 1'b1 && b < 50) begin tick(); b++; end
    if (b >= 50) to = 1'b1;
    tick();
  endtask

  task automatic drive_load(input int sel, input logic [7:0] w [8], input int nw, output bit to);
    int b;
    bit t;
    to = 1'b0;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    for (int k = 0; k < nw; k++) begin
      send_word(sel, w[k], t);
      to |= t;
    end
    set_cfg(sel, 1'b0, 8'h00);
    b = 0;
    while (((sel == 0) ? busy_a : busy_b) && b < 60) begin tick(); b++; end
    if (b >= 60) to = 1'b1;
  endtask

  task automatic test_reset();
    preset_a = 1'b1; preset_b = 1'b1;
    tick(); tick();
    preset_a = 1'b0; preset_b = 1'b0;
    n_total++; if (ifa.cfg_ready !== 1'b0) $display("FAIL reset_cfg_ready got %b want 0", ifa.cfg_ready); else n_pass++;
    n_total++; if (head_a !== 1'b0) $display("FAIL reset_ccff_head got %b want 0", head_a); else n_pass++;
    n_total++; if (en_a !== 1'b0) $display("FAIL reset_config_enable got %b want 0", en_a); else n_pass++;
    n_total++; if (ifa.rb_valid !== 1'b0) $display("FAIL reset_rb_valid got %b want 0", ifa.rb_valid); else n_pass++;
    n_total++; if (ifa.rb_data !== 8'h00) $display("FAIL reset_rb_data got %h want 00", ifa.rb_data); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else n_pass++;
    n_total++; if (done_a !== 1'b0) $display("FAIL reset_done got %b want 0", done_a); else n_pass++;
    n_total++; if ({busy_b, ifb.cfg_ready} !== 2'b00) $display("FAIL reset_b got %b want 00", {busy_b, ifb.cfg_ready}); else n_pass++;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n_total++; if ({busy_a, ifa.cfg_ready} !== 2'b11) $display("FAIL start_accept got %b want 11", {busy_a, ifa.cfg_ready}); else n_pass++;
    preset_a = 1'b1; tick(); preset_a = 1'b0;
    n_total++; if (busy_a !== 1'b0) $display("FAIL reset_from_fetch got %b want 0", busy_a); else n_pass++;
  endtask

  task automatic check_load(input string tag, input int sel, input logic [7:0] r [8], input int nw,
                            input int sh0, input int dn0, input int rb0, input bit to);
    int bad;
    n_total++; if (to) $display("FAIL %s_timeout got 1 want 0", tag); else n_pass++;
    n_total++;
    if (((sel == 0) ? sh_a : sh_b) - sh0 != ((sel == 0) ? NA : NB))
      $display("FAIL %s_shifts got %0d want %0d", tag, ((sel == 0) ? sh_a : sh_b) - sh0, (sel == 0) ? NA : NB);
    else n_pass++;
    n_total++;
    if (((sel == 0) ? dn_a : dn_b) - dn0 != 1) $display("FAIL %s_done got %0d want 1", tag, ((sel == 0) ? dn_a : dn_b) - dn0);
    else n_pass++;
    n_total++;
    if (((sel == 0) ? rbq_a.size() : rbq_b.size()) - rb0 != nw)
      $display("FAIL %s_rb_count got %0d want %0d", tag, ((sel == 0) ? rbq_a.size() : rbq_b.size()) - rb0, nw);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < nw; k++) begin
      if (sel == 0) begin if (rb0 + k >= rbq_a.size() || rbq_a[rb0 + k] !== r[k]) bad++; end
      else begin if (rb0 + k >= rbq_b.size() || rbq_b[rb0 + k] !== r[k]) bad++; end
    end
    n_total++; if (bad != 0) $display("FAIL %s_rb_data got %0d bad words want 0", tag, bad); else n_pass++;
    n_total++; if (chain_err(sel) != 0) $display("FAIL %s_chain got %0d bad bits want 0", tag, chain_err(sel)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [8];
    logic [7:0] r [8];
    int sh0, dn0, rb0, ru0, ga0, bad;
    bit to;
    for (int k = 0; k < 8; k++) w[k] = 8'(k + 1);
    model_load(0, w, 6, r);
    sh0 = sh_a; dn0 = dn_a; rb0 = rbq_a.size(); ru0 = runs_a.size(); ga0 = gaps_a.size();
    drive_load(0, w, 6, to);
    check_load("full", 0, r, 6, sh0, dn0, rb0, to);
    bad = 0;
    if (runs_a.size() - ru0 != 6) bad++;
    for (int k = ru0; k < runs_a.size(); k++) if (runs_a[k] != 8) bad++;
    n_total++; if (bad != 0) $display("FAIL enable_runs got %0d bad want 0", bad); else n_pass++;
    bad = 0;
    if (gaps_a.size() - ga0 != 5) bad++;
    for (int k = ga0; k < gaps_a.size(); k++) if (gaps_a[k] != 1) bad++;
    n_total++; if (bad != 0) $display("FAIL enable_gaps got %0d bad want 0", bad); else n_pass++;
  endtask

  task automatic test_readback();
    logic [7:0] w [8];
    logic [7:0] r [8];
    int sh0, dn0, rb0, bad;
    bit to;
    for (int k = 0; k < 8; k++) w[k] = 8'(k + 1);
    model_load(0, w, 6, r);
    sh0 = sh_a; dn0 = dn_a; rb0 = rbq_a.size();
    drive_load(0, w, 6, to);
    check_load("reload", 0, r, 6, sh0, dn0, rb0, to);
    bad = 0;
    for (int k = 0; k < 6; k++) if (rb0 + k >= rbq_a.size() || rbq_a[rb0 + k] !== 8'(k + 1)) bad++;
    n_total++; if (bad != 0) $display("FAIL readback_seq got %0d bad want 0", bad); else n_pass++;
  endtask

  task automatic test_partial_word();
    logic [7:0] w [8];
    logic [7:0] r [8];
    int sh0, dn0, rb0, ru0;
    bit to;
    for (int k = 0; k < 8; k++) w[k] = 8'($urandom);
    model_load(1, w, 2, r);
    sh0 = sh_b; dn0 = dn_b; rb0 = rbq_b.size(); ru0 = runs_b.size();
    drive_load(1, w, 2, to);
    check_load("part_rand", 1, r, 2, sh0, dn0, rb0, to);
    n_total++;
    if (runs_b.size() - ru0 != 2 || runs_b[ru0] != 8 || runs_b[ru0 + 1] != 2)
      $display("FAIL part_runs got %0d entries want 8,2", runs_b.size() - ru0);
    else n_pass++;
    w[0] = 8'hFF; w[1] = 8'hAB;
    model_load(1, w, 2, r);
    sh0 = sh_b; dn0 = dn_b; rb0 = rbq_b.size();
    drive_load(1, w, 2, to);
    check_load("part_ffab", 1, r, 2, sh0, dn0, rb0, to);
    n_total++;
    if (rbq_b.size() < rb0 + 2 || rbq_b[rb0 + 1][7:2] !== 6'd0)
      $display("FAIL part_rb_upper got %h want bits 7:2 zero", (rbq_b.size() >= rb0 + 2) ? rbq_b[rb0 + 1] : 8'hxx);
    else n_pass++;
    n_total++; if (chain_b !== 10'h3FF) $display("FAIL part_chain got %h want 3ff", chain_b); else n_pass++;
  endtask

  task automatic test_stall_ignore();
    logic [7:0] w [8];
    logic [7:0] r [8];
    int sh0, dn0, rb0, sh1, bad, b;
    bit to, t;
    sh0 = sh_a;
    bad = 0;
    set_cfg(0, 1'b1, 8'($urandom));
    for (int i = 0; i < 3; i++) begin tick(); if (ifa.cfg_ready !== 1'b0 || busy_a !== 1'b0) bad++; end
    set_cfg(0, 1'b0, 8'h00);
    n_total++; if (bad != 0 || sh_a != sh0) $display("FAIL idle_valid got %0d bad, %0d shifts want 0", bad, sh_a - sh0); else n_pass++;
    for (int k = 0; k < 8; k++) w[k] = 8'($urandom);
    model_load(0, w, 6, r);
    sh0 = sh_a; dn0 = dn_a; rb0 = rbq_a.size();
    start_a = 1'b1; tick(); start_a = 1'b0;
    send_word(0, w[0], to);
    set_cfg(0, 1'b0, 8'h00);
    b = 0;
    while (ifa.cfg_ready !== 1'b1 && b < 50) begin tick(); b++; end
    if (b >= 50) to = 1'b1;
    sh1 = sh_a;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start_a = (i == 2);
      tick();
      if (en_a !== 1'b0) bad++;
    end
    start_a = 1'b0;
    n_total++; if (bad != 0 || sh_a != sh1) $display("FAIL stall_hold got %0d bad, %0d shifts want 0", bad, sh_a - sh1); else n_pass++;
    for (int k = 1; k < 6; k++) begin
      if (k == 3) start_a = 1'b1;
      send_word(0, w[k], t);
      start_a = 1'b0;
      to |= t;
    end
    set_cfg(0, 1'b0, 8'h00);
    b = 0;
    while (done_a !== 1'b1 && b < 50) begin tick(); b++; end
    if (b >= 50) to = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n_total++; if (busy_a !== 1'b0) $display("FAIL start_on_done got busy=%b want 0", busy_a); else n_pass++;
    check_load("stall", 0, r, 6, sh0, dn0, rb0, to);
    start_a = 1'b1; tick(); start_a = 1'b0;
    n_total++; if ({busy_a, ifa.cfg_ready} !== 2'b11) $display("FAIL start_after_done got %b want 11", {busy_a, ifa.cfg_ready}); else n_pass++;
    preset_a = 1'b1; tick(); preset_a = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] w [8];
    logic [7:0] r [8];
    logic [7:0] r0, unused;
    int sh0, dn0, rb0;
    bit to, t;
    for (int k = 0; k < 8; k++) w[k] = 8'($urandom);
    r0 = model_word(0, w[0], 8);
    unused = model_word(0, w[1], 3);
    sh0 = sh_a; dn0 = dn_a; rb0 = rbq_a.size();
    start_a = 1'b1; tick(); start_a = 1'b0;
    send_word(0, w[0], to);
    send_word(0, w[1], t);
    to |= t;
    set_cfg(0, 1'b0, 8'h00);
    tick(); tick();
    preset_a = 1'b1; tick(); preset_a = 1'b0;
    n_total++;
    if ({en_a, busy_a, ifa.cfg_ready, ifa.rb_valid} !== 4'b0000)
      $display("FAIL mid_reset_outputs got %b want 0000", {en_a, busy_a, ifa.cfg_ready, ifa.rb_valid});
    else n_pass++;
    tick(); tick(); tick();
    n_total++; if (to) $display("FAIL mid_reset_timeout got 1 want 0"); else n_pass++;
    n_total++; if (sh_a - sh0 != 11) $display("FAIL mid_reset_shifts got %0d want 11", sh_a - sh0); else n_pass++;
    n_total++;
    if (dn_a != dn0 || rbq_a.size() - rb0 != 1) $display("FAIL mid_reset_pulses got done=%0d rb=%0d want 0,1", dn_a - dn0, rbq_a.size() - rb0);
    else n_pass++;
    n_total++;
    if (rbq_a.size() <= rb0 || rbq_a[rb0] !== r0) $display("FAIL mid_reset_rb0 got %h want %h", (rbq_a.size() > rb0) ? rbq_a[rb0] : 8'hxx, r0);
    else n_pass++;
    n_total++; if (chain_err(0) != 0) $display("FAIL mid_reset_chain got %0d bad want 0", chain_err(0)); else n_pass++;
    for (int k = 0; k < 8; k++) w[k] = 8'($urandom);
    model_load(0, w, 6, r);
    sh0 = sh_a; dn0 = dn_a; rb0 = rbq_a.size();
    drive_load(0, w, 6, to);
    check_load("after_reset", 0, r, 6, sh0, dn0, rb0, to);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    preset_a = 1'b1; preset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    set_cfg(0, 1'b0, 8'h00); set_cfg(1, 1'b0, 8'h00);
    for (int i = 0; i < NA; i++) init_val_a[i] = 1'($urandom);
    for (int i = 0; i < NB; i++) init_val_b[i] = 1'($urandom);
    for (int i = 0; i < NA; i++) mq_a.push_back(init_val_a[i]);
    for (int i = 0; i < NB; i++) mq_b.push_back(init_val_b[i]);
    init_a = 1'b1; init_b = 1'b1;
    tick();
    init_a = 1'b0; init_b = 1'b0;
    test_reset();
    test_back_to_back();
    test_readback();
    test_partial_word();
    test_stall_ignore();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
